// File: rtl/bridge_tx_buffered.sv
// Buffered host-link transmit bridge: queues read responses and emits each as an ASCII hex frame M<hex>CR LF.
// Define BRIDGE_TX_WRITE_ACK_EN to also queue writes and send them as short M CR LF acknowledgement frames.
module bridge_tx_buffered #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_WIDTH-1:0]         rdata_i,
  input  logic                          rw_i,
  input  logic                          valid_i,
  output logic [7:0]                    data_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic                          overflow_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int N     = DATA_WIDTH / 4;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(N - 1);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_DIGIT, S_CR, S_LF} state_t;

  state_t                 state_q;
  logic [DATA_WIDTH-1:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       wptr_q, rptr_q;
  logic [CNT_W-1:0]       count_q;
  logic [DATA_WIDTH-1:0]  buf_q;
  logic [IDX_W-1:0]       idx_q;
  logic                   overflow_q;
  logic [7:0]             data_q;
  logic                   valid_q;
  logic                   buf_wr;
  logic                   push_req, push_ok, pop, xfer;

`ifdef BRIDGE_TX_WRITE_ACK_EN
  logic typ_mem_q [FIFO_DEPTH];
  logic buf_wr_q;
  assign push_req = valid_i;
  assign buf_wr   = buf_wr_q;
`else
  assign push_req = valid_i & ~rw_i;
  assign buf_wr   = 1'b0;
`endif

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  function automatic logic [3:0] nibble(input logic [DATA_WIDTH-1:0] b, input logic [IDX_W-1:0] i);
    return 4'(b >> {i, 2'b00});
  endfunction

  assign xfer    = valid_q & ready_i;
  // Pops only happen where the FSM loads the shift buffer: from IDLE, or on the LF transfer.
  assign pop     = (count_q != '0) && ((state_q == S_IDLE) || ((state_q == S_LF) && xfer));
  assign push_ok = push_req && ((count_q != DEPTH_C) || pop);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wptr_q] <= rdata_i;
`ifdef BRIDGE_TX_WRITE_ACK_EN
      typ_mem_q[wptr_q] <= rw_i;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop)     rptr_q <= rptr_q + 1'b1;
      if (push_ok && !pop)      count_q <= count_q + 1'b1;
      else if (!push_ok && pop) count_q <= count_q - 1'b1;
      if (push_req && !push_ok) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q <= '0;
`ifdef BRIDGE_TX_WRITE_ACK_EN
      buf_wr_q <= 1'b0;
`endif
    end else if (pop) begin
      buf_q <= mem_q[rptr_q];
`ifdef BRIDGE_TX_WRITE_ACK_EN
      buf_wr_q <= typ_mem_q[rptr_q];
`endif
    end
  end

  // Each state computes the byte for the next state so data_o/valid_o stay registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            state_q <= S_PRE;
            data_q  <= 8'h4D;
            valid_q <= 1'b1;
          end
        end
        S_PRE: begin
          if (xfer) begin
            if (buf_wr) begin
              state_q <= S_CR;
              data_q  <= 8'h0D;
            end else begin
              state_q <= S_DIGIT;
              idx_q   <= TOP_IDX;
              data_q  <= hex_ascii(nibble(buf_q, TOP_IDX));
            end
          end
        end
        S_DIGIT: begin
          if (xfer) begin
            if (idx_q == '0) begin
              state_q <= S_CR;
              data_q  <= 8'h0D;
            end else begin
              idx_q  <= idx_q - 1'b1;
              data_q <= hex_ascii(nibble(buf_q, idx_q - 1'b1));
            end
          end
        end
        S_CR: begin
          if (xfer) begin
            state_q <= S_LF;
            data_q  <= 8'h0A;
          end
        end
        S_LF: begin
          if (xfer) begin
            if (pop) begin
              state_q <= S_PRE;
              data_q  <= 8'h4D;
            end else begin
              state_q <= S_IDLE;
              data_q  <= 8'h00;
              valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign data_o       = data_q;
  assign valid_o      = valid_q;
  assign overflow_o   = overflow_q;
  assign fifo_count_o = count_q;

endmodule

// File: tb/tb_bridge_tx_buffered.sv
// Scoreboard bench for bridge_tx_buffered: expected frame bytes are queued at stimulus time and a monitor checks every transfer.
module tb_bridge_tx_buffered;
  localparam int DW = 16;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH) + 1;
`ifdef BRIDGE_TX_WRITE_ACK_EN
  localparam bit WACK = 1'b1;
`else
  localparam bit WACK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] rdata_i;
  logic          rw_i, valid_i, ready_i;
  logic [7:0]    data_o;
  logic          valid_o, overflow_o;
  logic [CW-1:0] fifo_count_o;

  logic [31:0]   rdata32;
  logic          valid32;
  logic [7:0]    data32;
  logic          vo32, ovf32;
  logic [CW-1:0] cnt32;

  bridge_tx_buffered #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst_n(rst_n), .rdata_i(rdata_i), .rw_i(rw_i), .valid_i(valid_i),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .overflow_o(overflow_o), .fifo_count_o(fifo_count_o));

  bridge_tx_buffered #(.DATA_WIDTH(32), .FIFO_DEPTH(DEPTH)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .rdata_i(rdata32), .rw_i(1'b0), .valid_i(valid32),
    .data_o(data32), .valid_o(vo32), .ready_i(1'b1),
    .overflow_o(ovf32), .fifo_count_o(cnt32));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pushed_frames = 0;
  int done_frames = 0;
  logic [7:0] exp_q[$];
  bit         last_q[$];
  logic [7:0] frame_tmp[$];
  logic [7:0] got32[$];
  bit         hold;
  logic [7:0] hold_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame contents straight from the protocol description: 'M', digits MSB first, CR, LF.
  function automatic void build_frame(input bit wr, input logic [31:0] d, input int nd);
    int n;
    frame_tmp.delete();
    frame_tmp.push_back(8'h4D);
    if (!wr)
      for (int i = nd - 1; i >= 0; i--) begin
        n = (d >> (4 * i)) & 15;
        frame_tmp.push_back(8'((n < 10) ? (48 + n) : (55 + n)));
      end
    frame_tmp.push_back(8'h0D);
    frame_tmp.push_back(8'h0A);
  endfunction

  function automatic void add_frame(input bit wr, input logic [31:0] d);
    build_frame(wr, d, DW / 4);
    foreach (frame_tmp[i]) begin
      exp_q.push_back(frame_tmp[i]);
      last_q.push_back(i == frame_tmp.size() - 1);
    end
    pushed_frames++;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        check("hold_valid", {31'b0, valid_o}, 32'd1);
        check("hold_data", {24'b0, data_o}, {24'b0, hold_data});
      end
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: actual %0h required none at %0t", data_o, $time);
        end else begin
          check("byte", {24'b0, data_o}, {24'b0, exp_q.pop_front()});
          if (last_q.pop_front()) done_frames++;
        end
      end
      hold = valid_o && !ready_i;
      hold_data = data_o;
    end
  end

  always @(negedge clk)
    if (rst_n && vo32) got32.push_back(data32);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit wr, input logic [DW-1:0] d, input bit accepted);
    valid_i = 1'b1;
    rw_i    = wr;
    rdata_i = d;
    if (accepted && (!wr || WACK)) add_frame(wr, {16'h0, d});
    tick();
    valid_i = 1'b0;
    rw_i    = 1'b0;
  endtask

  task automatic drain(input bit rand_ready);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || valid_o) && n < 2000) begin
      ready_i = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      tick();
      n++;
    end
    ready_i = 1'b1;
    check("drain_done", exp_q.size(), 0);
    check("drain_idle", {31'b0, valid_o}, 0);
  endtask

  task automatic count_run(input string name, input int want);
    int n;
    n = 0;
    while (valid_o && n < 40) begin
      n++;
      tick();
    end
    check(name, n, want);
  endtask

  initial begin
    int base;
    bit wr;
    rst_n = 1'b0; valid_i = 1'b0; rw_i = 1'b0; rdata_i = '0; ready_i = 1'b1;
    rdata32 = '0; valid32 = 1'b0;
    tick(); tick();
    check("rst_data", {24'b0, data_o}, 0);
    check("rst_valid", {31'b0, valid_o}, 0);
    check("rst_ovf", {31'b0, overflow_o}, 0);
    check("rst_count", {28'b0, fifo_count_o}, 0);
    rst_n = 1'b1;
    tick();

    // Single read: latency and frame length
    valid_i = 1'b1; rdata_i = 16'h12AF; add_frame(1'b0, 32'h12AF);
    @(posedge clk); #1;
    valid_i = 1'b0;
    check("lat_count", {28'b0, fifo_count_o}, 1);
    check("lat_valid0", {31'b0, valid_o}, 0);
    tick();
    check("lat_valid1", {31'b0, valid_o}, 1);
    check("lat_pre", {24'b0, data_o}, 32'h4D);
    check("lat_count0", {28'b0, fifo_count_o}, 0);
    count_run("single_len", 7);
    check("single_count", {28'b0, fifo_count_o}, 0);

    // Write followed by read
    push(1'b1, 16'h0000, 1'b1);
    push(1'b0, 16'h00FF, 1'b1);
    drain(1'b0);

    // Back-to-back frames with ready held high are contiguous
    push(1'b0, 16'hA5C3, 1'b1);
    push(1'b0, 16'h9B07, 1'b1);
    count_run("contig_len", 14);
    drain(1'b0);

    // Back-pressure with three consecutive reads
    for (int i = 1; i <= 3; i++) begin
      ready_i = ($urandom_range(0, 1) != 0);
      push(1'b0, 16'(i), 1'b1);
    end
    drain(1'b1);

    // Overflow: one frame stalled in flight, then fill and overflow the FIFO
    base = done_frames;
    ready_i = 1'b0;
    push(1'b0, 16'h1111, 1'b1);
    tick(); tick();
    check("ovf_inflight", {28'b0, fifo_count_o}, 0);
    for (int i = 0; i < DEPTH; i++) push(1'b0, 16'(16'h2000 + i), 1'b1);
    check("ovf_full", {28'b0, fifo_count_o}, DEPTH);
    check("ovf_clear", {31'b0, overflow_o}, 0);
    push(1'b0, 16'hDEAD, 1'b0);
    check("ovf_set", {31'b0, overflow_o}, 1);
    check("ovf_count", {28'b0, fifo_count_o}, DEPTH);
    drain(1'b0);
    check("ovf_frames", done_frames - base, DEPTH + 1);
    check("ovf_sticky", {31'b0, overflow_o}, 1);

    // Reset during the DIGIT state with two entries queued
    ready_i = 1'b0;
    for (int i = 0; i < 3; i++) push(1'b0, 16'(16'h3456 + i), 1'b1);
    tick();
    check("rstm_count", {28'b0, fifo_count_o}, 2);
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    last_q.delete();
    #1;
    check("rstm_data", {24'b0, data_o}, 0);
    check("rstm_valid", {31'b0, valid_o}, 0);
    check("rstm_ovf", {31'b0, overflow_o}, 0);
    check("rstm_count0", {28'b0, fifo_count_o}, 0);
    tick();
    rst_n = 1'b1;
    ready_i = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("rstm_quiet", {31'b0, valid_o}, 0);

    // Randomized traffic, never exceeding capacity
    for (int c = 0; c < 400; c++) begin
      ready_i = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) != 0) begin
        wr = ($urandom_range(0, 3) == 0);
        if ((!wr || WACK) && (pushed_frames - done_frames >= DEPTH)) begin
          tick();
        end else begin
          push(wr, 16'($urandom), 1'b1);
        end
      end else begin
        tick();
      end
    end
    drain(1'b1);
    check("rand_no_ovf", {31'b0, overflow_o}, 0);

    // 32-bit instance
    got32.delete();
    rdata32 = 32'hDEADBEEF;
    valid32 = 1'b1;
    tick();
    valid32 = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    build_frame(1'b0, 32'hDEADBEEF, 8);
    check("w32_len", got32.size(), frame_tmp.size());
    for (int i = 0; i < frame_tmp.size() && i < got32.size(); i++)
      check("w32_byte", {24'b0, got32[i]}, {24'b0, frame_tmp[i]});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
